// File: rtl/comp_checker.sv
// comp_checker: scoreboard for a WIDTH-bit unsigned magnitude comparator.
// Each accepted vector is checked against the expected lt/gt/eq flags and
// counted as pass or fail. Per-campaign coverage of every (x,y) pair is
// recorded, and the first failing operands are captured.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset
//   start_i      begin a campaign (honoured in IDLE and DONE only)
//   in_valid_i   x_i/y_i/xly_i/xgy_i/xey_i carry a vector
//   in_ready_o   vector accepted this cycle when in_valid_i is high
//   x_i, y_i     comparator operands
//   xly_i, xgy_i, xey_i  comparator outputs under test
//   busy_o       campaign running
//   done_o       every (x,y) pair has been seen
//   pass_cnt_o, fail_cnt_o  saturating result counters
//   err_o        sticky mismatch flag
//   err_x_o, err_y_o  operands of the first mismatch
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting and checking vectors
// DONE  | coverage complete, results held until next start
module comp_checker #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             xly_i,
    input  logic             xgy_i,
    input  logic             xey_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [WIDTH-1:0] err_x_o,
    output logic [WIDTH-1:0] err_y_o
);

    localparam int NCOV = 1 << (2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NCOV-1:0]    cov_q, cov_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   err_x_q, err_x_d;
    logic [WIDTH-1:0]   err_y_q, err_y_d;

    logic               accept;
    logic               mismatch;
    logic [2*WIDTH-1:0] cov_idx;

    assign accept  = in_valid_i && (state_q == RUN);
    assign cov_idx = {x_i, y_i};
    // Compare all three flags independently so non-one-hot outputs always fail.
    assign mismatch = (xly_i != (x_i < y_i)) ||
                      (xgy_i != (x_i > y_i)) ||
                      (xey_i != (x_i == y_i));

    always_comb begin
        state_d = state_q;
        cov_d   = cov_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        err_x_d = err_x_q;
        err_y_d = err_y_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    cov_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    err_d   = 1'b0;
                    err_x_d = '0;
                    err_y_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cov_d[cov_idx] = 1'b1;
                    if (mismatch) begin
                        if (fail_q != '1) fail_d = fail_q + 1'b1;
                        if (!err_q) begin
                            err_d   = 1'b1;
                            err_x_d = x_i;
                            err_y_d = y_i;
                        end
                    end else begin
                        if (pass_q != '1) pass_d = pass_q + 1'b1;
                    end
                    if (&cov_d) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cov_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            err_x_q <= '0;
            err_y_q <= '0;
        end else begin
            state_q <= state_d;
            cov_q   <= cov_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            err_x_q <= err_x_d;
            err_y_q <= err_y_d;
        end
    end

    assign in_ready_o = (state_q == RUN);
    assign busy_o     = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
    assign err_o      = err_q;
    assign err_x_o    = err_x_q;
    assign err_y_o    = err_y_q;

endmodule
